// File: rtl/issue_buff_ooo.sv
// issue_buff_ooo: age-ordered collapsing issue queue that offers the oldest entry
// whose source tags are all marked done; IN_ORDER=1 restricts issue to the head.
module issue_buff_ooo #(
    parameter int DATA_WIDTH = 47,
    parameter int ELEMENTS   = 4,
    parameter int NUM_DEPS   = 2,
    parameter int NUM_TAGS   = 30,
    parameter int TAG_BITS   = 5,
    parameter int IN_ORDER   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic [NUM_DEPS*TAG_BITS-1:0] din_deps,
    input  logic [NUM_DEPS-1:0]          din_dep_valid,
    input  logic                         din_valid,
    output logic                         din_ready,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    input  logic [NUM_TAGS-1:0]          done_flags,
    output logic [$clog2(ELEMENTS+1)-1:0] occupancy
);
    localparam int CW = $clog2(ELEMENTS + 1);
    localparam int SW = $clog2(ELEMENTS);
    localparam int TW = 2 ** TAG_BITS;

    logic [DATA_WIDTH-1:0]        r_data [ELEMENTS];
    logic [NUM_DEPS*TAG_BITS-1:0] r_tags [ELEMENTS];
    logic [NUM_DEPS-1:0]          r_dv   [ELEMENTS];
    logic [CW-1:0]                r_count;
    logic [TW-1:0]                w_done;
    logic [ELEMENTS-1:0]          w_cand;
    logic [SW-1:0]                w_sel;
    logic [CW-1:0]                w_wr;
    logic                         w_found;
    logic                         w_issue;
    logic                         w_enq;

    // zero-padding makes tags >= NUM_TAGS permanently unsatisfied
    assign w_done = TW'(done_flags);

    always_comb begin
        w_cand = '0;
        for (int s = 0; s < ELEMENTS; s++) begin
            w_cand[s] = (CW'(s) < r_count) && (IN_ORDER == 0 || s == 0);
            for (int d = 0; d < NUM_DEPS; d++)
                if (r_dv[s][d] && !w_done[r_tags[s][d*TAG_BITS +: TAG_BITS]]) w_cand[s] = 1'b0;
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int s = ELEMENTS - 1; s >= 0; s--)
            if (w_cand[s]) begin
                w_found = 1'b1;
                w_sel   = SW'(s);
            end
    end

    assign dout_valid = w_found;
    assign dout       = r_data[w_sel];
    assign din_ready  = r_count != CW'(ELEMENTS);
    assign occupancy  = r_count;
    assign w_issue    = w_found & dout_ready;
    assign w_enq      = din_valid & din_ready;
    assign w_wr       = r_count - CW'(w_issue);

    always_ff @(posedge clk) begin
        if (rst || flush) r_count <= '0;
        else              r_count <= r_count + CW'(w_enq) - CW'(w_issue);
    end

    // collapse above the issued slot, then the new entry lands at the youngest position
    always_ff @(posedge clk) begin
        for (int s = 0; s < ELEMENTS - 1; s++)
            if (w_issue && SW'(s) >= w_sel) begin
                r_data[s] <= r_data[s+1];
                r_tags[s] <= r_tags[s+1];
                r_dv[s]   <= r_dv[s+1];
            end
        if (w_enq) begin
            r_data[SW'(w_wr)] <= din;
            r_tags[SW'(w_wr)] <= din_deps;
            r_dv[SW'(w_wr)]   <= din_dep_valid;
        end
    end
endmodule

// File: doc/issue_buff_ooo.md
Name: issue_buff_ooo

Overview:
- Parametrised, age-ordered out-of-order issue buffer (reservation station); next generation of the in-order sequential issue buffer.
- Holds up to ELEMENTS instructions, each with up to NUM_DEPS source tags. Each cycle it offers the oldest entry whose dependencies are all satisfied by done_flags.
- Sits between rename/dispatch and an execution unit. IN_ORDER=1 restricts issue to the head only, reproducing the old in-order behaviour.

Parameters:
- DATA_WIDTH, 47, payload width carried unmodified.
- ELEMENTS, 4, buffer depth (>=2).
- NUM_DEPS, 2, source-dependency slots per entry.
- NUM_TAGS, 30, width of done_flags.
- TAG_BITS, 5, width of one dependency tag (2^TAG_BITS >= NUM_TAGS).
- IN_ORDER, 0, 1 = only the oldest entry may issue.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous clear of all entries (e.g. mispredict).
- din  in  DATA_WIDTH  instruction payload.
- din_deps  in  NUM_DEPS*TAG_BITS  source tags; dep i at [i*TAG_BITS+:TAG_BITS].
- din_dep_valid  in  NUM_DEPS  bit i=1: dep i is live.
- din_valid  in  1  enqueue request.
- din_ready  out  1  buffer can accept.
- dout  out  DATA_WIDTH  payload of the selected entry.
- dout_valid  out  1  a ready entry is offered.
- dout_ready  in  1  consumer accepts.
- done_flags  in  NUM_TAGS  bit t=1: tag t result available.
- occupancy  out  clog2(ELEMENTS+1)  number of valid entries.

Behaviour:
- Storage is a collapsing queue. Slot 0 is oldest. Valid slots are contiguous from 0; count = occupancy.
- Entry readiness (combinational): for every dep i, either dep_valid[i]=0, or (tag < NUM_TAGS and done_flags[tag]=1).
  - A tag >= NUM_TAGS is never satisfied.
  - Readiness is re-evaluated every cycle from current done_flags; no latching of wakeups.
- Selection: the lowest-index valid ready slot. If IN_ORDER=1, only slot 0 is a candidate.
- dout_valid = a candidate exists. dout = that slot's payload; it is don't-care but stable-by-slot when dout_valid=0. Combinational from state and done_flags.
- din_ready = (count < ELEMENTS). It is registered-state-derived only, with no combinational path from dout_ready. Full + simultaneous issue still gives din_ready=0.
- issue = dout_valid & dout_ready. enq = din_valid & din_ready.
- Clock edge, priority order:
  1. rst: all slots invalid, count=0. Payload/tag contents don't-care.
  2. flush: same as rst. A concurrent enq and issue are discarded.
  3. Otherwise:
     - If issue from slot k: slots k+1..count-1 shift down by one, preserving order.
     - If enq: the new entry is written at index count (no issue) or count-1 (with issue), i.e. the youngest position.
     - count += enq - issue.
- A newly enqueued entry is never eligible in its enqueue cycle (one-cycle minimum latency din -> dout), even if its deps are already done.
- Empty: dout_valid=0, din_ready=1. Full: din_ready=0.
- Reset values: dout_valid=0, din_ready=1, occupancy=0.
- Throughput: one enqueue and one issue per cycle sustained.
- Deasserting done_flags bits may revoke readiness. A consumer stalling with dout_ready=0 must tolerate dout changing.

Test Plan:
- Reset, then enqueue A (no deps) -> cycle after: dout_valid=1, dout=A, occupancy=1. Accept -> occupancy=0, dout_valid=0.
- Enqueue A (dep tag 3), B (dep tag 7), C (no deps); done_flags=0 -> dout=C. Issue C, set done_flags[7]=1 -> dout=B. Issue B -> occupancy=1, A still held.
- IN_ORDER=1, same stimulus as above -> dout_valid=0 until done_flags[3]=1, then dout=A, then B, then C in order.
- Fill 4 entries -> din_ready=0. Issue the middle entry (slot 2) while din_valid=1 -> no write that cycle. Next cycle din_ready=1, remaining order is slots 0,1,3; new entry enqueues at slot 3.
- Simultaneous enq+issue at occupancy=2 for 10 cycles -> occupancy stays 2, issue order equals enqueue order.
- Occupancy=3, assert flush with din_valid=1 -> next cycle occupancy=0, dout_valid=0. Likewise rst mid-stream -> occupancy=0, din_ready=1.
